// File: rtl/clk_div_ctrl.sv
// Programmable clock-divider sequencer: owns the divide counter and active ratio,
// applies ratio changes and start/stop only on whole-period boundaries.
module clk_div_ctrl #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [WIDTH-1:0] cnt,
    output logic             cnt_rstn,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] div, div_nx;
    logic [WIDTH-1:0] pend_div, pend_nx;
    logic [WIDTH-1:0] cnt_nx;
    logic             hs, legal, wrap, has_pend, active;
    logic             err_nx, clk_out_nx, tick_nx, ready_nx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            div       <= WIDTH'(DEFAULT_DIV);
            pend_div  <= '0;
            cnt       <= '0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
            cfg_err   <= 1'b0;
            busy      <= 1'b0;
            cnt_rstn  <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            state     <= state_nx;
            div       <= div_nx;
            pend_div  <= pend_nx;
            cnt       <= cnt_nx;
            clk_out   <= clk_out_nx;
            tick      <= tick_nx;
            cfg_err   <= err_nx;
            busy      <= active;
            cnt_rstn  <= active;
            cfg_ready <= ready_nx;
        end
    end

    always_comb begin
        hs       = cfg_valid & cfg_ready;
        legal    = cfg_div >= WIDTH'(2);
        wrap     = (cnt == div - WIDTH'(1));
        // pend_div == 0 doubles as "no ratio pending" since legal ratios are >= 2
        has_pend = (pend_div != '0);
        err_nx   = hs & ~legal;
        state_nx = state;
        div_nx   = div;
        pend_nx  = pend_div;
        cnt_nx   = wrap ? '0 : cnt + WIDTH'(1);

        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (hs && legal) div_nx = cfg_div;
                if (en) state_nx = RUN;
            end
            RUN: begin
                if (hs && legal) begin
                    pend_nx  = cfg_div;
                    state_nx = PEND;
                end
                if (!en) state_nx = STOP;
            end
            PEND: begin
                if (wrap) begin
                    div_nx   = pend_div;
                    pend_nx  = '0;
                    state_nx = en ? RUN : STOP;
                end else if (!en) begin
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (wrap) begin
                    if (has_pend) div_nx = pend_div;
                    pend_nx  = '0;
                    state_nx = IDLE;
                end else if (en) begin
                    // resuming with a captured ratio must still apply it at the boundary
                    state_nx = has_pend ? PEND : RUN;
                end
            end
            default: state_nx = IDLE;
        endcase

        active     = (state_nx != IDLE);
        clk_out_nx = active && (cnt_nx < div_nx - (div_nx >> 1));
        tick_nx    = active && (cnt_nx == div_nx - WIDTH'(1));
        ready_nx   = (state_nx == IDLE) || (state_nx == RUN);
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a period-level reference model predicts every
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_clk_div_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_div = '0;
    logic        cfg_ready, cfg_err, cnt_rstn, clk_out, tick, busy;
    logic [15:0] cnt;

    clk_div_ctrl #(.WIDTH(16), .DEFAULT_DIV(4)) dut (
        .clk(clk), .rstn(rstn), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .cnt(cnt), .cnt_rstn(cnt_rstn),
        .clk_out(clk_out), .tick(tick), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cnt;
        logic ready, err, crst, cko, tick, busy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;

    // Reference model in period terms: clock on/off, stop requested, pending ratio.
    bit m_on, m_stopping, m_err;
    int m_div, m_pend, m_pos;

    function automatic bit m_ready();
        return !m_on || (!m_stopping && m_pend == 0);
    endfunction

    task automatic model_reset();
        m_on = 0; m_stopping = 0; m_err = 0;
        m_div = 4; m_pend = 0; m_pos = 0;
    endtask

    task automatic model_step(input bit e, input bit v, input int d);
        bit hs, ok, last;
        hs   = v && m_ready();
        ok   = d >= 2;
        last = m_on && (m_pos == m_div - 1);
        m_err = hs && !ok;
        if (!m_on) begin
            if (hs && ok) m_div = d;
            if (e) begin m_on = 1; m_pos = 0; end
        end else begin
            if (last) begin
                if (m_pend != 0) begin m_div = m_pend; m_pend = 0; end
                m_pos = 0;
                if (m_stopping) begin m_on = 0; m_stopping = 0; end
                else if (!e) m_stopping = 1;
            end else begin
                m_pos++;
                m_stopping = !e;
            end
            if (hs && ok) m_pend = d;
        end
    endtask

    function automatic exp_t exp_now();
        exp_t x;
        x.cnt   = m_on ? m_pos : 0;
        x.ready = m_ready();
        x.err   = m_err;
        x.crst  = m_on;
        x.busy  = m_on;
        x.cko   = m_on && (m_pos < m_div - m_div / 2);
        x.tick  = m_on && (m_pos == m_div - 1);
        return x;
    endfunction

    // Monitor: DUT presents a new output set every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t x;
            cyc++;
            checks++;
            if (q.size() == 0) begin
                $display("FAIL scoreboard_empty cycle %0d: no expected entry queued", cyc);
            end else begin
                x = q.pop_front();
                if (cnt == 16'(x.cnt) && cfg_ready == x.ready && cfg_err == x.err &&
                    cnt_rstn == x.crst && clk_out == x.cko && tick == x.tick && busy == x.busy)
                    passes++;
                else
                    $display("FAIL outputs cycle %0d: got cnt=%0d rdy=%b err=%b crst=%b cko=%b tick=%b busy=%b, expected cnt=%0d rdy=%b err=%b crst=%b cko=%b tick=%b busy=%b",
                             cyc, cnt, cfg_ready, cfg_err, cnt_rstn, clk_out, tick, busy,
                             x.cnt, x.ready, x.err, x.crst, x.cko, x.tick, x.busy);
            end
        end
    end

    // Called #1 after a rising edge; the queue then holds only this cycle's entry.
    task automatic drive(input bit e, input bit v, input int d);
        rstn = 1'b1; en = e; cfg_valid = v; cfg_div = 16'(d);
        model_step(e, v, d);
        q.push_back(exp_now());
        @(posedge clk); #1;
    endtask

    task automatic reset_now();
        q.delete();
        rstn = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        model_reset();
        q.push_back(exp_now());
        q.push_back(exp_now());
        @(posedge clk); #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0);
    endtask

    task automatic go_idle();
        for (int i = 0; i < 400 && m_on; i++) drive(0, 0, 0);
        drive(0, 0, 0);
    endtask

    task automatic run_to_pos(input int p);
        for (int i = 0; i < 400 && !(m_on && m_pos == p); i++) drive(1, 0, 0);
    endtask

    initial begin
        bit e;
        @(posedge clk); #1;
        mon_en = 1'b1;
        reset_now();
        for (int i = 0; i < 4; i++) drive(0, 0, 0);
        run(9);
        go_idle();
        drive(0, 1, 5);
        run(16);
        go_idle();
        drive(0, 1, 4);
        run_to_pos(1);
        drive(1, 1, 7);
        run(24);
        go_idle();
        drive(0, 1, 4);
        run(3);
        drive(1, 1, 1);
        run(10);
        go_idle();
        drive(0, 1, 6);
        run(7);
        run_to_pos(0);
        for (int i = 0; i < 9; i++) drive(0, 0, 0);
        run(8);
        run_to_pos(0);
        drive(0, 1, 3);
        for (int i = 0; i < 9; i++) drive(0, 0, 0);
        run(10);
        drive(0, 1, 300);
        run(620);
        go_idle();
        run(2);
        drive(1, 1, 7);
        drive(1, 0, 0);
        reset_now();
        run(10);
        e = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                reset_now();
            end else begin
                if ($urandom_range(0, 15) == 0) e = !e;
                drive(e, $urandom_range(0, 7) == 0,
                      ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 9));
            end
        end
        @(negedge clk); #1;
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
